// File: rtl/hit_resolver.sv
// Two-player hit resolution: hitbox/hurtbox overlap, one-cycle hit pulses, damage/block, round result.
// Block-charge regeneration is compiled in only when BLOCK_REGEN_EN is defined.
module hit_resolver #(
    parameter logic [2:0] HEALTH_INIT  = 3'd5,
    parameter logic [2:0] BLOCK_INIT   = 3'd3,
    parameter int         REGEN_FRAMES = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  gamestate,
    input  logic [3:0]  p1_state,
    input  logic [3:0]  p2_state,
    input  logic [39:0] p1_basic_box,
    input  logic [39:0] p2_basic_box,
    input  logic [39:0] p1_dir_box,
    input  logic [39:0] p2_dir_box,
    input  logic [39:0] p1_hurt_box,
    input  logic [39:0] p2_hurt_box,
    output logic [1:0]  p1_hitFlag,
    output logic [1:0]  p2_hitFlag,
    output logic [2:0]  p1_health,
    output logic [2:0]  p2_health,
    output logic [2:0]  p1_block,
    output logic [2:0]  p2_block,
    output logic        round_over,
    output logic [1:0]  winner
);

    localparam logic [2:0] GS_FIGHT   = 3'd2;
    localparam logic [3:0] ST_BACK    = 4'd2;
    localparam logic [3:0] ST_BASIC   = 4'd4;
    localparam logic [3:0] ST_DIR     = 4'd7;
    localparam logic [3:0] ST_HITSTUN = 4'd9;
    localparam logic [3:0] ST_BLKSTUN = 4'd10;

    if (REGEN_FRAMES < 1) begin : g_bad_regen_frames
        $error("REGEN_FRAMES must be at least 1");
    end

    // Index 0 is player 1, index 1 is player 2.
    logic [3:0]  state_w [2];
    logic [39:0] basic_w [2];
    logic [39:0] dir_w   [2];
    logic [39:0] hurt_w  [2];

    logic [1:0]  flag_q    [2];
    logic [1:0]  flag_d    [2];
    logic [2:0]  health_q  [2];
    logic [2:0]  health_nx [2];
    logic [2:0]  block_q   [2];
    logic [2:0]  block_nx  [2];
    logic        done_q    [2];
    logic        hit_w     [2];
    logic        use_blk_w [2];
    logic        round_over_q;
    logic [1:0]  winner_q;
    logic        fight_w;

`ifdef BLOCK_REGEN_EN
    localparam int RW = (REGEN_FRAMES > 1) ? $clog2(REGEN_FRAMES) : 1;
    logic [RW-1:0] regen_q [2];
`endif

    assign state_w[0] = p1_state;
    assign state_w[1] = p2_state;
    assign basic_w[0] = p1_basic_box;
    assign basic_w[1] = p2_basic_box;
    assign dir_w[0]   = p1_dir_box;
    assign dir_w[1]   = p2_dir_box;
    assign hurt_w[0]  = p1_hurt_box;
    assign hurt_w[1]  = p2_hurt_box;
    assign fight_w    = (gamestate == GS_FIGHT);

    // Boxes are packed {x1,x2,y1,y2}; edges touching count as overlap.
    function automatic logic overlap(input logic [39:0] a, input logic [39:0] b);
        return (a[39:30] <= b[29:20]) && (b[39:30] <= a[29:20]) &&
               (a[19:10] <= b[9:0])   && (b[19:10] <= a[9:0]);
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            flag_d[i]    = 2'b00;
            hit_w[i]     = 1'b0;
            use_blk_w[i] = 1'b0;
            health_nx[i] = health_q[i];
            block_nx[i]  = block_q[i];
        end
        for (int i = 0; i < 2; i++) begin
            hit_w[i] = fight_w && !round_over_q && !done_q[i] &&
                       (state_w[1-i] != ST_HITSTUN) && (state_w[1-i] != ST_BLKSTUN) &&
                       (((state_w[i] == ST_BASIC) && overlap(basic_w[i], hurt_w[1-i])) ||
                        ((state_w[i] == ST_DIR)   && overlap(dir_w[i],   hurt_w[1-i])));
            if (hit_w[i]) begin
                flag_d[1-i] = (state_w[i] == ST_DIR) ? 2'b10 : 2'b01;
            end
        end
        // Damage lands as the pulse ends, judged against the defender's current stance.
        for (int i = 0; i < 2; i++) begin
            if (flag_q[i] != 2'b00) begin
                if ((state_w[i] == ST_BACK) && (block_q[i] != 3'd0)) begin
                    use_blk_w[i] = 1'b1;
                    block_nx[i]  = block_q[i] - 3'd1;
                end else if (flag_q[i] == 2'b10) begin
                    health_nx[i] = (health_q[i] > 3'd2) ? health_q[i] - 3'd2 : 3'd0;
                end else begin
                    health_nx[i] = (health_q[i] != 3'd0) ? health_q[i] - 3'd1 : 3'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !fight_w) begin
            for (int i = 0; i < 2; i++) begin
                flag_q[i]   <= 2'b00;
                health_q[i] <= HEALTH_INIT;
                block_q[i]  <= BLOCK_INIT;
                done_q[i]   <= 1'b0;
`ifdef BLOCK_REGEN_EN
                regen_q[i]  <= '0;
`endif
            end
            round_over_q <= 1'b0;
            winner_q     <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                flag_q[i]   <= flag_d[i];
                health_q[i] <= health_nx[i];
                block_q[i]  <= block_nx[i];
                if ((state_w[i] != ST_BASIC) && (state_w[i] != ST_DIR)) begin
                    done_q[i] <= 1'b0;
                end else if (hit_w[i]) begin
                    done_q[i] <= 1'b1;
                end
`ifdef BLOCK_REGEN_EN
                if (use_blk_w[i]) begin
                    regen_q[i] <= '0;
                end else if (!round_over_q && (block_q[i] < BLOCK_INIT)) begin
                    if (regen_q[i] == RW'(REGEN_FRAMES - 1)) begin
                        regen_q[i] <= '0;
                        block_q[i] <= block_q[i] + 3'd1;
                    end else begin
                        regen_q[i] <= regen_q[i] + 1'b1;
                    end
                end
`endif
            end
            // Winner bits: {p1 dead, p2 dead} maps directly onto 10 / 01 / 11.
            if (!round_over_q && ((health_q[0] == 3'd0) || (health_q[1] == 3'd0))) begin
                round_over_q <= 1'b1;
                winner_q     <= {health_q[0] == 3'd0, health_q[1] == 3'd0};
            end
        end
    end

    assign p1_hitFlag = flag_q[0];
    assign p2_hitFlag = flag_q[1];
    assign p1_health  = health_q[0];
    assign p2_health  = health_q[1];
    assign p1_block   = block_q[0];
    assign p2_block   = block_q[1];
    assign round_over = round_over_q;
    assign winner     = winner_q;

endmodule
